// File: rtl/seq_divider_32_bit_pkg.sv
// Shared constants and FSM state type for the sequential signed divider.
package seq_divider_32_bit_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_ITER  = 32;
   localparam int unsigned DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_32_bit_div_step.sv
// One restoring division step: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module seq_divider_32_bit_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      // rem < dvs before the shift, so the 33-bit difference never overflows its sign bit
      trial  = rem_sh - {1'b0, dvs};
      if (trial[WIDTH]) begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider_32_bit.sv
// Multi-cycle signed divider: magnitudes are divided by restoring steps, then signs are applied in FIX.
module seq_divider_32_bit
   import seq_divider_32_bit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sign_q_q, sign_q_d;
   logic             sign_r_q, sign_r_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_by_zero_q, div_by_zero_d;

   logic [WIDTH-1:0] step_rem, step_quo;
   logic [WIDTH-1:0] dividend_mag, divisor_mag;

   seq_divider_32_bit_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dvs      (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      dividend_mag  = dividend[WIDTH-1] ? -dividend : dividend;
      divisor_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;

      state_d       = state_q;
      cnt_d         = cnt_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      dvs_d         = dvs_q;
      sign_q_d      = sign_q_q;
      sign_r_d      = sign_r_q;
      dbz_d         = dbz_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvs_d    = divisor_mag;
               quo_d    = dividend_mag;
               sign_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sign_r_d = dividend[WIDTH-1];
               cnt_d    = '0;
               busy_d   = 1'b1;
               dbz_d    = (divisor == '0);
               // divide-by-zero parks |dividend| in rem so FIX re-signs it back to the dividend
               rem_d    = (divisor == '0) ? dividend_mag : '0;
               state_d  = (divisor == '0) ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            quotient_d    = dbz_q ? '1 : (sign_q_q ? -quo_q : quo_q);
            remainder_d   = sign_r_q ? -rem_q : rem_q;
            div_by_zero_d = dbz_q;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvs_q         <= '0;
         sign_q_q      <= 1'b0;
         sign_r_q      <= 1'b0;
         dbz_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         dvs_q         <= dvs_d;
         sign_q_q      <= sign_q_d;
         sign_r_q      <= sign_r_d;
         dbz_q         <= dbz_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider_32_bit.sv
// Self-checking bench for seq_divider_32_bit: directed cases plus random operands vs. an arithmetic model.
module tb_seq_divider_32_bit;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   seq_divider_32_bit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Truncating signed division with the divider's zero-divisor and overflow conventions.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic z);
      int sa, sb;
      sa = a;
      sb = b;
      z  = 1'b0;
      if (sb == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         z = 1'b1;
      end else if (a == 32'h8000_0000 && sb == -1) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endtask

   // Waits (bounded) for done; returns the number of edges since the start edge.
   task automatic wait_done(input string tag, output int unsigned n);
      logic seen;
      int unsigned busy_drop;
      n = 0;
      seen = 1'b0;
      busy_drop = 0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done) seen = 1'b1;
         else if (!busy) busy_drop++;
      end
      check({tag, " busy_held"}, busy_drop, 0);
   endtask

   task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input int unsigned n);
      logic [31:0] eq, er;
      logic        ez;
      ref_div(a, b, eq, er, ez);
      check({tag, " latency"}, n, (b == 0) ? 1 : 33);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
      check({tag, " busy_at_done"}, {31'b0, busy}, 0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      int unsigned n;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, " busy_after_start"}, {31'b0, busy}, 1);
      wait_done(tag, n);
      check_result(tag, a, b, n);
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, {31'b0, done}, 0);
   endtask

   initial begin
      int unsigned n;
      int unsigned extra_done;
      logic [31:0] ra, rb;

      clr = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'b0, busy}, 0);
      check("reset done", {31'b0, done}, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset dbz", {31'b0, div_by_zero}, 0);
      @(negedge clk);
      clr = 1'b0;

      run_op("100/7", 32'd100, 32'd7);
      run_op("-100/7", -32'sd100, 32'd7);
      run_op("100/-7", 32'd100, -32'sd7);
      run_op("-100/-7", -32'sd100, -32'sd7);
      run_op("5/0", 32'd5, 32'd0);
      run_op("9/3", 32'd9, 32'd3);
      run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("-1/min", 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("-7/0", -32'sd7, 32'd0);
      run_op("min/0", 32'h8000_0000, 32'd0);

      // start during busy is ignored, then back-to-back start in the done cycle
      @(negedge clk);
      dividend = 32'd12;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      dividend = 32'd99;
      divisor  = 32'd1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dividend = 32'd7;
      divisor  = 32'd0;
      n = 11;
      begin
         int unsigned m;
         wait_done("12/5 ignore", m);
         n = m + 11;
      end
      check_result("12/5 ignore", 32'd12, 32'd5, n);
      dividend = 32'd50;
      divisor  = 32'd6;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b busy", {31'b0, busy}, 1);
      check("b2b done_one_cycle", {31'b0, done}, 0);
      wait_done("50/6 b2b", n);
      check_result("50/6 b2b", 32'd50, 32'd6, n);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      clr = 1'b1;
      #1;
      check("midclr busy", {31'b0, busy}, 0);
      check("midclr done", {31'b0, done}, 0);
      check("midclr quotient", quotient, 0);
      check("midclr remainder", remainder, 0);
      check("midclr dbz", {31'b0, div_by_zero}, 0);
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      extra_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) extra_done++;
      end
      check("midclr no_done", extra_done, 0);
      run_op("21/4", 32'd21, 32'd4);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: rb = $urandom_range(1, 20);
            4: rb = -$urandom_range(1, 20);
            5: ra = $urandom_range(0, 1000);
            default: ;
         endcase
         run_op($sformatf("rnd%0d %h/%h", i, ra, rb), ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
